// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Sequencing controller for the multicycle RV32I core (one shared ALU, one
// unified instruction/data memory). Each instruction walks through
// FETCH / DECODE / EXECUTE / MEM / WB states. The block drives every datapath
// select and enable, and decodes op/funct3/funct7 from the latched IR.
//
// Optional feature: define PERF_CNT_EN to add the cycle_cnt and instret_cnt
// performance counters (width PERF_W). With the macro undefined, the counters,
// their ports and the PERF_W parameter are absent.
//
// Ports
//   clk          core clock; all state updates on the rising edge
//   reset        synchronous, active-high
//   op           IR[6:0]
//   funct3       IR[14:12]
//   funct7       IR[30]
//   zero         ALU zero flag, used in BRANCH
//   mem_ready    memory completes the access this cycle
//   pc_write     load PC this cycle
//   ir_write     latch instruction + old PC
//   adr_src      0 = PC, 1 = ALUOut to the memory address
//   mem_read     memory read request, held until mem_ready
//   mem_write    memory write request, held until mem_ready
//   alu_src_a    00 = PC, 01 = oldPC, 10 = rs1
//   alu_src_b    00 = rs2, 01 = imm, 10 = const 4
//   alu_control  000 add, 001 sub, 010 and, 011 or, 101 slt
//   result_src   00 = ALUOut, 01 = mem data, 10 = ALU result
//   imm_src      00 I, 01 S, 10 B, 11 J
//   reg_write    register file write enable
//   illegal      sticky flag: unsupported opcode seen; cleared only by reset
//   state_o      current state encoding (debug)
//   cycle_cnt    (PERF_CNT_EN) +1 every non-reset cycle
//   instret_cnt  (PERF_CNT_EN) +1 per completed instruction
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm
`ifdef PERF_CNT_EN
#(
    parameter int unsigned PERF_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state_o
`ifdef PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
`endif
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StJalr     = 4'd11
    } state_t;

    // Moore part of the control word, registered alongside the state.
    typedef struct packed {
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] result_src;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   illegal_q;
    logic   illegal_op;
    logic   fetch_done;
    logic   branch_taken;

    // Only R-type with funct7 set turns funct3=000 into a subtract.
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7,
                                           input logic r_type);
        logic [2:0] ctl;
        unique case (f3)
            3'b000:  ctl = (r_type && f7) ? 3'b001 : 3'b000;
            3'b110:  ctl = 3'b011;
            3'b111:  ctl = 3'b010;
            3'b010:  ctl = 3'b101;
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    // op/funct come from the latched IR, so they are stable for every state
    // after DECODE and can feed the registered control word.
    function automatic ctrl_t moore_ctrl(input state_t s, input logic [6:0] opc,
                                         input logic [2:0] f3, input logic f7);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.mem_read   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            StDecode: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            StMemAdr: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            StMemRead: begin
                c.adr_src  = 1'b1;
                c.mem_read = 1'b1;
            end
            StMemWb: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            StMemWrite: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            StExecR: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = alu_dec(f3, f7, 1'b1);
            end
            StExecI: begin
                c.alu_src_a   = 2'b10;
                c.alu_src_b   = 2'b01;
                c.alu_control = alu_dec(f3, f7, 1'b0);
            end
            StAluWb: begin
                // oldPC+4 for the jump link value; unused for plain ALU ops.
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.reg_write  = 1'b1;
                // JALR's ALUOut holds the target, so the link comes straight off the ALU.
                c.result_src = (opc == OpJalr) ? 2'b10 : 2'b00;
            end
            StBranch: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = 3'b001;
            end
            StJal: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_write  = 1'b1;
            end
            StJalr: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_write   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJal:      state_d = StAluWb;
            StJalr:     state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            ctrl_q      <= moore_ctrl(StFetch, op, funct3, funct7);
            illegal_q   <= 1'b0;
`ifdef PERF_CNT_EN
            cycle_cnt   <= '0;
            instret_cnt <= '0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_ctrl(state_d, op, funct3, funct7);
            if (illegal_op) illegal_q <= 1'b1;
`ifdef PERF_CNT_EN
            cycle_cnt <= cycle_cnt + PERF_W'(1);
            // A return to FETCH straight from DECODE is a skipped illegal op.
            if (state_d == StFetch && state_q != StFetch && state_q != StDecode) begin
                instret_cnt <= instret_cnt + PERF_W'(1);
            end
`endif
        end
    end

    assign fetch_done   = (state_q == StFetch) && mem_ready;
    assign branch_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

    // While reset is held every enable and select is forced low.
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        result_src  = 2'b00;
        imm_src     = 2'b00;
        reg_write   = 1'b0;
        if (!reset) begin
            pc_write    = ctrl_q.pc_write || fetch_done ||
                          ((state_q == StBranch) && branch_taken);
            ir_write    = fetch_done;
            adr_src     = ctrl_q.adr_src;
            mem_read    = ctrl_q.mem_read;
            mem_write   = ctrl_q.mem_write;
            alu_src_a   = ctrl_q.alu_src_a;
            alu_src_b   = ctrl_q.alu_src_b;
            alu_control = ctrl_q.alu_control;
            result_src  = ctrl_q.result_src;
            reg_write   = ctrl_q.reg_write;
            case (op)
                OpStore:  imm_src = 2'b01;
                OpBranch: imm_src = 2'b10;
                OpJal:    imm_src = 2'b11;
                default:  imm_src = 2'b00;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mr, mw, adr;
        logic [1:0] sa, sb;
        logic [2:0] ac;
        logic [1:0] rs, imm;
    } obs_t;

    typedef struct packed {
        logic       rst, z, mr;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
    } stim_t;

    logic       clk, reset, funct7, zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state_o;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_ctrl_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .result_src(result_src), .imm_src(imm_src), .reg_write(reg_write),
        .illegal(illegal), .state_o(state_o)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    obs_t obs;
    assign obs = {state_o, pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
                  alu_src_a, alu_src_b, alu_control, result_src, imm_src};

    obs_t  exp_q[$];
    obs_t  care_q[$];
    stim_t stim_q[$];
    int    checks = 0;
    int    failures = 0;

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic f7,
                                           input logic r_type);
        if (f3 == 3'b000) return (r_type && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b010) return 3'b101;
        return 3'b000;
    endfunction

    // Expected outputs for one cycle in state st; care marks the bits that matter.
    function automatic void model(input stim_t s, input logic [3:0] st,
                                  output obs_t e, output obs_t care);
        e = '0;
        care = '0;
        e.st = st;
        care.st = 4'hf;
        {care.pcw, care.irw, care.rw, care.mr, care.mw} = 5'b11111;
        if (s.rst) begin
            care = '1;
            return;
        end
        case (st)
            4'd0: begin
                e.mr = 1'b1; care.adr = 1'b1;
                e.irw = s.mr; e.pcw = s.mr;
                e.sb = 2'b10; care.sa = 2'b11; care.sb = 2'b11; care.ac = 3'b111;
            end
            4'd1: begin
                e.sa = 2'b01; e.sb = 2'b01;
                care.sa = 2'b11; care.sb = 2'b11; care.ac = 3'b111;
            end
            4'd2: begin
                e.sa = 2'b10; e.sb = 2'b01;
                care.sa = 2'b11; care.sb = 2'b11; care.ac = 3'b111;
            end
            4'd3: begin
                e.adr = 1'b1; care.adr = 1'b1; e.mr = 1'b1;
            end
            4'd4: begin
                e.rs = 2'b01; care.rs = 2'b11; e.rw = 1'b1;
            end
            4'd5: begin
                e.adr = 1'b1; care.adr = 1'b1; e.mw = 1'b1;
                e.imm = 2'b01; care.imm = 2'b11;
            end
            4'd6: begin
                e.sa = 2'b10; e.sb = 2'b00; e.ac = exp_alu(s.f3, s.f7, 1'b1);
                care.sa = 2'b11; care.sb = 2'b11; care.ac = 3'b111;
            end
            4'd7: begin
                e.sa = 2'b10; e.sb = 2'b01; e.ac = exp_alu(s.f3, s.f7, 1'b0);
                care.sa = 2'b11; care.sb = 2'b11; care.ac = 3'b111;
            end
            4'd8: begin
                e.rw = 1'b1;
                e.rs = (s.op == OP_JR) ? 2'b10 : 2'b00;
                care.rs = 2'b11;
                if (s.op == OP_JAL || s.op == OP_JR) begin
                    e.sa = 2'b01; e.sb = 2'b10; care.sa = 2'b11; care.sb = 2'b11;
                end
            end
            4'd9: begin
                e.sa = 2'b10; e.sb = 2'b00; e.ac = 3'b001; e.rs = 2'b00;
                care.sa = 2'b11; care.sb = 2'b11; care.ac = 3'b111; care.rs = 2'b11;
                e.pcw = ((s.f3 == 3'b000) && s.z) || ((s.f3 == 3'b001) && !s.z);
            end
            4'd10: begin
                e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
                care.sa = 2'b11; care.sb = 2'b11; care.ac = 3'b111; care.rs = 2'b11;
            end
            4'd11: begin
                e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1;
                care.sa = 2'b11; care.sb = 2'b11; care.ac = 3'b111; care.rs = 2'b11;
            end
            default: care = '0;
        endcase
    endfunction

    // Queue one cycle of stimulus with its expected outcome.
    task automatic push(input logic [3:0] st, input logic mr, input logic z, input logic rst);
        stim_t s;
        obs_t  e, k;
        s = '{rst: rst, z: z, mr: mr, op: cur_op, f3: cur_f3, f7: cur_f7};
        model(s, st, e, k);
        stim_q.push_back(s);
        exp_q.push_back(e);
        care_q.push_back(k);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        cur_op = o;
        cur_f3 = f3;
        cur_f7 = f7;
    endtask

    task automatic test_reset();
        stim_t s;
        obs_t  e, k;
        reset = 1'b1; zero = 1'b0; mem_ready = 1'b0;
        op = 7'd0; funct3 = 3'd0; funct7 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        set_instr(OP_R, 3'b000, 1'b0);
        push(4'd0, 1'b1, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, zero, mem_ready, op, funct3, funct7} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            k = care_q.pop_front();
            checks++;
            if ((obs & k) !== (e & k)) begin
                failures++;
                $display("FAIL reset_state: got %h required %h (care %h)", obs, e, k);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_illegal: got %b required 0", illegal);
        end
`ifdef PERF_CNT_EN
        checks++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d required 0/0", cycle_cnt, instret_cnt);
        end
        push(4'd0, 1'b1, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 1'b0);
        push(4'd6, 1'b1, 1'b0, 1'b0);
        push(4'd8, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, zero, mem_ready, op, funct3, funct7} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            k = care_q.pop_front();
            checks++;
            if ((obs & k) !== (e & k)) begin
                failures++;
                $display("FAIL perf_add: got %h required %h (care %h)", obs, e, k);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (cycle_cnt !== 32'd4 || instret_cnt !== 32'd1) begin
            failures++;
            $display("FAIL perf_counts: got %0d/%0d required 4/1", cycle_cnt, instret_cnt);
        end
`endif
    endtask

    // R/I ALU ops: add, sub, addi (funct7 ignored), or, and, slt, xor(->add).
    task automatic test_alu();
        stim_t s;
        obs_t  e, k;
        logic [10:0] tbl [7];
        tbl[0] = {OP_R, 3'b000, 1'b0};
        tbl[1] = {OP_R, 3'b000, 1'b1};
        tbl[2] = {OP_I, 3'b000, 1'b1};
        tbl[3] = {OP_R, 3'b110, 1'b0};
        tbl[4] = {OP_I, 3'b111, 1'b0};
        tbl[5] = {OP_R, 3'b010, 1'b0};
        tbl[6] = {OP_R, 3'b100, 1'b1};
        for (int i = 0; i < 7; i++) begin
            set_instr(tbl[i][10:4], tbl[i][3:1], tbl[i][0]);
            push(4'd0, 1'b1, 1'b0, 1'b0);
            push(4'd1, 1'b1, 1'b0, 1'b0);
            push((cur_op == OP_R) ? 4'd6 : 4'd7, 1'b1, 1'b0, 1'b0);
            push(4'd8, 1'b1, 1'b0, 1'b0);
        end
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, zero, mem_ready, op, funct3, funct7} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            k = care_q.pop_front();
            checks++;
            if ((obs & k) !== (e & k)) begin
                failures++;
                $display("FAIL alu op=%b f3=%b: got %h required %h (care %h)",
                         s.op, s.f3, obs, e, k);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_wait();
        stim_t s;
        obs_t  e, k;
        set_instr(OP_LD, 3'b010, 1'b0);
        push(4'd0, 1'b0, 1'b0, 1'b0);
        push(4'd0, 1'b1, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 1'b0);
        push(4'd2, 1'b1, 1'b0, 1'b0);
        repeat (3) push(4'd3, 1'b0, 1'b0, 1'b0);
        push(4'd3, 1'b1, 1'b0, 1'b0);
        push(4'd4, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, zero, mem_ready, op, funct3, funct7} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            k = care_q.pop_front();
            checks++;
            if ((obs & k) !== (e & k)) begin
                failures++;
                $display("FAIL load_wait: got %h required %h (care %h)", obs, e, k);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_store();
        stim_t s;
        obs_t  e, k;
        set_instr(OP_ST, 3'b010, 1'b0);
        push(4'd0, 1'b1, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 1'b0);
        push(4'd2, 1'b1, 1'b0, 1'b0);
        push(4'd5, 1'b0, 1'b0, 1'b0);
        push(4'd5, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, zero, mem_ready, op, funct3, funct7} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            k = care_q.pop_front();
            checks++;
            if ((obs & k) !== (e & k)) begin
                failures++;
                $display("FAIL store: got %h required %h (care %h)", obs, e, k);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // beq/bne against both zero values.
    task automatic test_branch();
        stim_t s;
        obs_t  e, k;
        for (int i = 0; i < 4; i++) begin
            set_instr(OP_BR, (i < 2) ? 3'b000 : 3'b001, 1'b0);
            push(4'd0, 1'b1, 1'b0, 1'b0);
            push(4'd1, 1'b1, 1'b0, 1'b0);
            push(4'd9, 1'b1, i[0], 1'b0);
        end
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, zero, mem_ready, op, funct3, funct7} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            k = care_q.pop_front();
            checks++;
            if ((obs & k) !== (e & k)) begin
                failures++;
                $display("FAIL branch f3=%b zero=%b: got %h required %h (care %h)",
                         s.f3, s.z, obs, e, k);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jump();
        stim_t s;
        obs_t  e, k;
        set_instr(OP_JAL, 3'b000, 1'b0);
        push(4'd0, 1'b1, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 1'b0);
        push(4'd10, 1'b1, 1'b0, 1'b0);
        push(4'd8, 1'b1, 1'b0, 1'b0);
        set_instr(OP_JR, 3'b000, 1'b0);
        push(4'd0, 1'b1, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 1'b0);
        push(4'd11, 1'b1, 1'b0, 1'b0);
        push(4'd8, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, zero, mem_ready, op, funct3, funct7} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            k = care_q.pop_front();
            checks++;
            if ((obs & k) !== (e & k)) begin
                failures++;
                $display("FAIL jump op=%b: got %h required %h (care %h)", s.op, obs, e, k);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        stim_t s;
        obs_t  e, k;
        for (int phase = 0; phase < 3; phase++) begin
            if (phase == 0) begin
                set_instr(7'b0000000, 3'b000, 1'b0);
                push(4'd0, 1'b1, 1'b0, 1'b0);
                push(4'd1, 1'b1, 1'b0, 1'b0);
            end else if (phase == 1) begin
                set_instr(OP_R, 3'b000, 1'b0);
                push(4'd0, 1'b1, 1'b0, 1'b0);
                push(4'd1, 1'b1, 1'b0, 1'b0);
                push(4'd6, 1'b1, 1'b0, 1'b0);
                push(4'd8, 1'b1, 1'b0, 1'b0);
            end else begin
                push(4'd0, 1'b1, 1'b0, 1'b1);
            end
            while (exp_q.size() > 0) begin
                s = stim_q.pop_front();
                {reset, zero, mem_ready, op, funct3, funct7} = s;
                @(negedge clk);
                e = exp_q.pop_front();
                k = care_q.pop_front();
                checks++;
                if ((obs & k) !== (e & k)) begin
                    failures++;
                    $display("FAIL illegal_seq%0d: got %h required %h (care %h)",
                             phase, obs, e, k);
                end
                @(posedge clk);
                #1;
            end
            checks++;
            if (illegal !== (phase < 2)) begin
                failures++;
                $display("FAIL illegal_flag%0d: got %b required %b", phase, illegal, phase < 2);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        stim_t s;
        obs_t  e, k;
        set_instr(OP_ST, 3'b010, 1'b0);
        push(4'd0, 1'b1, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 1'b0);
        push(4'd2, 1'b1, 1'b0, 1'b0);
        push(4'd5, 1'b0, 1'b0, 1'b0);
        push(4'd5, 1'b0, 1'b0, 1'b1);
        push(4'd0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, zero, mem_ready, op, funct3, funct7} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            k = care_q.pop_front();
            checks++;
            if ((obs & k) !== (e & k)) begin
                failures++;
                $display("FAIL reset_mid_store: got %h required %h (care %h)", obs, e, k);
            end
`ifdef PERF_CNT_EN
            if (s.rst) begin
                @(posedge clk);
                #1;
                checks++;
                if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
                    failures++;
                    $display("FAIL reset_mid_counters: got %0d/%0d required 0/0",
                             cycle_cnt, instret_cnt);
                end
                continue;
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        obs_t  e, k;
        set_instr(OP_R, 3'b000, 1'b1);
        push(4'd0, 1'b0, 1'b0, 1'b0);
        push(4'd0, 1'b0, 1'b0, 1'b0);
        push(4'd0, 1'b1, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 1'b0);
        push(4'd6, 1'b1, 1'b0, 1'b0);
        push(4'd8, 1'b1, 1'b0, 1'b0);
        set_instr(OP_LD, 3'b010, 1'b0);
        push(4'd0, 1'b1, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 1'b0);
        push(4'd2, 1'b1, 1'b0, 1'b0);
        push(4'd3, 1'b1, 1'b0, 1'b0);
        push(4'd4, 1'b1, 1'b0, 1'b0);
        set_instr(OP_BR, 3'b001, 1'b0);
        push(4'd0, 1'b1, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 1'b0);
        push(4'd9, 1'b1, 1'b0, 1'b0);
        set_instr(OP_I, 3'b110, 1'b0);
        push(4'd0, 1'b1, 1'b0, 1'b0);
        push(4'd1, 1'b1, 1'b0, 1'b0);
        push(4'd7, 1'b1, 1'b0, 1'b0);
        push(4'd8, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            {reset, zero, mem_ready, op, funct3, funct7} = s;
            @(negedge clk);
            e = exp_q.pop_front();
            k = care_q.pop_front();
            checks++;
            if ((obs & k) !== (e & k)) begin
                failures++;
                $display("FAIL back_to_back op=%b: got %h required %h (care %h)",
                         s.op, obs, e, k);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_branch();
        test_jump();
        test_illegal();
        test_reset_mid_store();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
